// File: rtl/rr_arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter: FSM state encoding
// and a constant-width helper.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Ceiling log2, clamped to 1 so a single-requester build still has a legal id width
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
// Double-width masked priority encoder, purely combinational.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int WID = 16,
    parameter int IDW = clog2(WID)
) (
    input  logic [WID-1:0] requests,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx,
    output logic [WID-1:0] onehot
);

    localparam int PW = IDW + 1;

    logic [2*WID-1:0] dbl;
    logic [2*WID-1:0] masked;
    logic [PW-1:0]    pos;

    always_comb begin
        dbl    = {requests, requests};
        masked = dbl & ({(2*WID){1'b1}} << ptr);
        found  = |requests;
        pos    = '0;
        // Descending scan so the lowest masked position is the one left in pos
        for (int i = 2*WID-1; i >= 0; i--) begin
            if (masked[i]) pos = PW'(i);
        end
        if (pos >= PW'(WID)) idx = IDW'(pos - PW'(WID));
        else                 idx = IDW'(pos);
        onehot = found ? (WID'(1) << idx) : '0;
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: each winner holds a registered one-hot grant
// for up to its weight in cycles, then priority rotates past it.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no owner; grants=0; a new burst starts when enable && requests
//   BURST | grant_id owns the resource; credit counts remaining cycles
module weighted_rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int WID = 16,
    parameter int CW  = 4,
    parameter int IDW = clog2(WID)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [WID-1:0]    requests,
    input  logic [WID*CW-1:0] weights,
    output logic [WID-1:0]    grants,
    output logic              grant_valid,
    output logic [IDW-1:0]    grant_id
);

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n, ptr_rel, pick_ptr;
    logic [CW-1:0]  credit, credit_n;
    logic [WID-1:0] grants_n;
    logic [IDW-1:0] grant_id_n;
    logic           grant_valid_n;

    logic           found;
    logic [IDW-1:0] win_idx;
    logic [WID-1:0] win_onehot;
    logic [CW-1:0]  win_w, eff_w;
    logic           keep, start;

    // Releasing owner moves priority one past itself, so it is scanned last
    assign ptr_rel  = (grant_id == IDW'(WID-1)) ? '0 : grant_id + 1'b1;
    assign pick_ptr = (state == BURST) ? ptr_rel : ptr;

    rr_pick #(.WID(WID), .IDW(IDW)) u_pick (
        .requests (requests),
        .ptr      (pick_ptr),
        .found    (found),
        .idx      (win_idx),
        .onehot   (win_onehot)
    );

    assign win_w = weights[win_idx*CW +: CW];
    assign eff_w = (win_w == '0) ? CW'(1) : win_w;
    assign keep  = requests[grant_id] && (credit > CW'(1));

    always_comb begin
        state_n       = state;
        ptr_n         = ptr;
        credit_n      = credit;
        grants_n      = grants;
        grant_id_n    = grant_id;
        grant_valid_n = grant_valid;
        start         = 1'b0;
        case (state)
            IDLE: begin
                if (enable && found) start = 1'b1;
            end
            BURST: begin
                if (keep) begin
                    credit_n = credit - 1'b1;
                end else begin
                    ptr_n = ptr_rel;
                    if (enable && found) begin
                        start = 1'b1;
                    end else begin
                        state_n       = IDLE;
                        credit_n      = '0;
                        grants_n      = '0;
                        grant_id_n    = '0;
                        grant_valid_n = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        if (start) begin
            state_n       = BURST;
            credit_n      = eff_w;
            grants_n      = win_onehot;
            grant_id_n    = win_idx;
            grant_valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            credit      <= '0;
            grants      <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            credit      <= credit_n;
            grants      <= grants_n;
            grant_id    <= grant_id_n;
            grant_valid <= grant_valid_n;
        end
    end

endmodule
